reg_bank_write_arbiter: RTL and testbench

Sequences writes into a bank of NREGS 32-bit level-sensitive register instances, each built from clocked RS/D latch cells with a shared `clk` and a per-register `enable`. Two requesters share the bank's single write datapath. A round-robin arbiter picks one request at a time. A four-state FSM then presents the data, pulses exactly one register enable for one full clock cycle, and acknowledges the winner. The block also keeps a wrapping count of completed writes for debug.

---
 rtl/reg_bank_write_arbiter.sv | 118 +++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write sequencer for a bank of NREGS 32-bit latch registers.
// Grants one of two requesters, presents data, pulses one enable, then acks.
module reg_bank_write_arbiter #(
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       data0,
  input  logic [31:0]       data1,
  output logic              ack0,
  output logic              ack1,
  output logic              busy,
  output logic [31:0]       reg_d,
  output logic [NREGS-1:0]  reg_en,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               busy_q, busy_d;
  logic [31:0]        reg_d_q, reg_d_d;
  logic [NREGS-1:0]   reg_en_q, reg_en_d;
  logic [15:0]        wr_count_q, wr_count_d;
  logic               grant;

  // Outputs are registered from the next-state decode, so each one lines up
  // with the state it belongs to while still coming straight from a flop.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    reg_d_d    = reg_d_q;
    reg_en_d   = '0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    wr_count_d = wr_count_q;
    grant      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester that did not win last time goes next.
          grant   = (req0 && req1) ? ~last_q : req1;
          id_d    = grant;
          last_d  = grant;
          addr_d  = grant ? addr1 : addr0;
          reg_d_d = grant ? data1 : data0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        reg_en_d[addr_q] = 1'b1;
        state_d          = WRITE;
      end
      WRITE: begin
        ack0_d     = ~id_q;
        ack1_d     = id_q;
        wr_count_d = wr_count_q + 16'd1;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      reg_d_q    <= '0;
      reg_en_q   <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      reg_d_q    <= reg_d_d;
      reg_en_q   <= reg_en_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Target index is only meaningful after a grant, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign reg_d    = reg_d_q;
  assign reg_en   = reg_en_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Randomized and directed bench for reg_bank_write_arbiter with a
// transaction-level reference model and a behavioural register bank.
module tb_reg_bank_write_arbiter;
  localparam int NREGS  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]       data0 = '0, data1 = '0;
  logic              ack0, ack1, busy;
  logic [31:0]       reg_d;
  logic [NREGS-1:0]  reg_en;
  logic [15:0]       wr_count;

  always #5 clk = ~clk;

  reg_bank_write_arbiter #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .reg_d(reg_d), .reg_en(reg_en), .wr_count(wr_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycles elapsed since the current grant (0 = idle).
  int                m_phase;
  logic              m_last, m_id;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_reg_d;
  logic [15:0]       m_count;

  logic [31:0] bank [NREGS];
  int          dut_grants[$];
  logic        saw_ack0, saw_ack1;
  bit          hold_mode, auto_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_last   = 1'b1;
    m_id     = 1'b0;
    m_addr   = '0;
    m_reg_d  = '0;
    m_count  = '0;
    saw_ack0 = 1'b0;
    saw_ack1 = 1'b0;
    dut_grants.delete();
  endtask

  task automatic model_edge();
    if (m_phase == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_id = ~m_last;
        else              m_id = req1;
        m_last  = m_id;
        m_addr  = m_id ? addr1 : addr0;
        m_reg_d = m_id ? data1 : data0;
        m_phase = 1;
      end
    end else if (m_phase == 3) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == 3) m_count = m_count + 16'd1;
    end
  endtask

  task automatic compare();
    logic [NREGS-1:0] e_en;
    e_en = '0;
    if (m_phase == 2) e_en[m_addr] = 1'b1;
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("reg_en", 32'(reg_en), 32'(e_en));
    chk("reg_d", reg_d, m_reg_d);
    chk("ack0", 32'(ack0), 32'(m_phase == 3 && m_id == 1'b0));
    chk("ack1", 32'(ack1), 32'(m_phase == 3 && m_id == 1'b1));
    chk("wr_count", 32'(wr_count), 32'(m_count));
  endtask

  task automatic rand_drive();
    if (!req0 && $urandom_range(2) == 0) begin
      req0 = 1'b1; addr0 = ADDR_W'($urandom_range(NREGS-1)); data0 = $urandom;
    end
    if (!req1 && $urandom_range(2) == 0) begin
      req1 = 1'b1; addr1 = ADDR_W'($urandom_range(NREGS-1)); data1 = $urandom;
    end
    // Disturb the in-flight requester's inputs; the transaction must not notice.
    if (m_phase != 0 && m_phase != 3 && $urandom_range(3) == 0) begin
      if (m_id == 1'b0) begin data0 = $urandom; addr0 = ADDR_W'($urandom_range(NREGS-1)); end
      else              begin data1 = $urandom; addr1 = ADDR_W'($urandom_range(NREGS-1)); end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (saw_ack0 && !hold_mode) req0 = 1'b0;
    if (saw_ack1 && !hold_mode) req1 = 1'b0;
    if (auto_drv) rand_drive();
    @(negedge clk);
    compare();
    for (int i = 0; i < NREGS; i++) if (reg_en[i]) bank[i] = reg_d;
    if (ack0) dut_grants.push_back(0);
    if (ack1) dut_grants.push_back(1);
    saw_ack0 = ack0;
    saw_ack1 = ack1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    hold_mode = 1'b0; auto_drv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int a0, a1;
    hold_mode = 1'b0; auto_drv = 1'b0;
    model_reset();
    for (int i = 0; i < NREGS; i++) bank[i] = '0;

    // Reset values
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_en", 32'(reg_en), 32'd0);
    chk("rst_reg_d", reg_d, 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    reset = 1'b0;

    // Single write
    req0 = 1'b1; addr0 = 2'd2; data0 = 32'hDEADBEEF;
    step();
    chk("t1_setup_en", 32'(reg_en), 32'd0);
    chk("t1_setup_d", reg_d, 32'hDEADBEEF);
    step();
    chk("t1_write_en", 32'(reg_en), 32'b0100);
    step();
    chk("t1_ack0", 32'(ack0), 32'd1);
    chk("t1_count", 32'(wr_count), 32'd1);
    step();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_bank2", bank[2], 32'hDEADBEEF);
    step();

    // Contention after reset
    do_reset();
    req0 = 1'b1; addr0 = 2'd0; data0 = 32'h11111111;
    req1 = 1'b1; addr1 = 2'd1; data1 = 32'h22222222;
    a0 = -1; a1 = -1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (ack0 && a0 < 0) a0 = k;
      if (ack1 && a1 < 0) a1 = k;
    end
    chk("t2_ack0_cycle", 32'(a0), 32'd3);
    chk("t2_ack_spacing", 32'(a1 - a0), 32'd4);
    chk("t2_bank0", bank[0], 32'h11111111);
    chk("t2_bank1", bank[1], 32'h22222222);

    // Fairness with both requests held
    do_reset();
    hold_mode = 1'b1;
    req0 = 1'b1; addr0 = 2'd0; data0 = 32'h11111111;
    req1 = 1'b1; addr1 = 2'd1; data1 = 32'h22222222;
    repeat (16) step();
    chk("t3_ngrants", 32'(dut_grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_grant_order", 32'((i < dut_grants.size()) ? dut_grants[i] : 99), 32'(i % 2));
    chk("t3_count", 32'(wr_count), 32'd4);
    hold_mode = 1'b0; req0 = 1'b0; req1 = 1'b0;

    // Input change mid-transaction
    do_reset();
    req0 = 1'b1; addr0 = 2'd3; data0 = 32'hA5A5A5A5;
    step();
    data0 = 32'h0; addr0 = 2'd1;
    repeat (4) step();
    chk("t4_bank3", bank[3], 32'hA5A5A5A5);

    // Reset during WRITE
    do_reset();
    req0 = 1'b1; addr0 = 2'd0; data0 = 32'h0F0F0F0F;
    step();
    step();
    chk("t5_write_en", 32'(reg_en), 32'b0001);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_async_en", 32'(reg_en), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ack0", 32'(ack0), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step();
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_count", 32'(wr_count), 32'd0);
    chk("t5_no_ack", 32'(dut_grants.size()), 32'd0);

    // Counter wrap
    do_reset();
    force dut.wr_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_count_q;
    m_count = 16'hFFFF;
    chk("t6_preload", 32'(wr_count), 32'h0000FFFF);
    req0 = 1'b1; addr0 = 2'd1; data0 = 32'hCAFEF00D;
    step();
    step();
    step();
    chk("t6_ack0", 32'(ack0), 32'd1);
    chk("t6_wrap", 32'(wr_count), 32'd0);
    step();

    // Randomized traffic against the model
    do_reset();
    auto_drv = 1'b1;
    repeat (800) step();
    auto_drv = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) step();
    chk("t7_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
